// File: rtl/mem_block_copier.sv
// rtl/mem_block_copier.sv - word-by-word DataMemory block copy engine
// Alternates one read and one write per word; all outputs are registered.
module mem_block_copier #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Start,
  input  logic [31:0]            SrcAddr,
  input  logic [31:0]            DstAddr,
  input  logic [COUNT_WIDTH-1:0] WordCount,
  input  logic [31:0]            ReadData,
  output logic [31:0]            Address,
  output logic [31:0]            WriteData,
  output logic                   MemWrite,
  output logic                   MemRead,
  output logic                   Busy,
  output logic                   Done,
  output logic                   Err
);

  typedef enum logic [2:0] {IDLE, READ, WRITE, FINISH, ERROR} stateT;

  stateT                  state;
  logic [31:0]            srcPtr;
  logic [31:0]            dstPtr;
  logic [COUNT_WIDTH-1:0] remaining;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state     <= IDLE;
      srcPtr    <= '0;
      dstPtr    <= '0;
      remaining <= '0;
      Address   <= '0;
      WriteData <= '0;
      MemWrite  <= 1'b0;
      MemRead   <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Err       <= 1'b0;
    end else begin
      // Outputs are loaded for the state being entered; idle values unless overridden.
      Address   <= '0;
      WriteData <= '0;
      MemWrite  <= 1'b0;
      MemRead   <= 1'b0;
      Busy      <= 1'b1;
      Done      <= 1'b0;
      Err       <= 1'b0;
      case (state)
        READ: begin
          srcPtr    <= srcPtr + 32'd4;
          WriteData <= ReadData;
          Address   <= dstPtr;
          MemWrite  <= 1'b1;
          state     <= WRITE;
        end
        WRITE: begin
          dstPtr    <= dstPtr + 32'd4;
          remaining <= remaining - COUNT_WIDTH'(1);
          if (remaining == COUNT_WIDTH'(1)) begin
            Done  <= 1'b1;
            state <= FINISH;
          end else begin
            Address <= srcPtr;
            MemRead <= 1'b1;
            state   <= READ;
          end
        end
        default: begin
          // IDLE, and the terminal states handing back to idle, accept a new request.
          if (Start) begin
            srcPtr    <= SrcAddr;
            dstPtr    <= DstAddr;
            remaining <= WordCount;
            if (SrcAddr[1:0] != 2'b00 || DstAddr[1:0] != 2'b00) begin
              Done  <= 1'b1;
              Err   <= 1'b1;
              state <= ERROR;
            end else if (WordCount == '0) begin
              Done  <= 1'b1;
              state <= FINISH;
            end else begin
              Address <= SrcAddr;
              MemRead <= 1'b1;
              state   <= READ;
            end
          end else begin
            Busy  <= 1'b0;
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_block_copier.sv
// tb/tb_mem_block_copier.sv - randomized bench for mem_block_copier
// Expected bus trace and memory image are planned per request from the copy rules.
module tb_mem_block_copier;
  localparam int CW = 16;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          Start;
  logic [31:0]   SrcAddr, DstAddr;
  logic [CW-1:0] WordCount;
  logic [31:0]   ReadData, Address, WriteData;
  logic          MemWrite, MemRead, Busy, Done, Err;

  mem_block_copier #(.COUNT_WIDTH(CW)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .SrcAddr(SrcAddr), .DstAddr(DstAddr),
    .WordCount(WordCount), .ReadData(ReadData), .Address(Address), .WriteData(WriteData),
    .MemWrite(MemWrite), .MemRead(MemRead), .Busy(Busy), .Done(Done), .Err(Err)
  );

  always #5 Clk = ~Clk;

  // 1 KiB memory, aliased over the full address space
  logic [31:0] mem    [256];
  logic [31:0] refMem [256];
  assign ReadData = mem[Address[9:2]];
  always @(posedge Clk) if (MemWrite) mem[Address[9:2]] = WriteData;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    logic        rd;
    logic        busy;
    logic        done;
    logic        err;
  } cycT;

  cycT expQ[$];
  int  checks = 0;
  int  failures = 0;
  bit  chkEn = 0;

  function automatic cycT mk(input logic [31:0] a, input logic [31:0] w,
                             input logic wr, input logic rd, input logic dn, input logic er);
    cycT c;
    c.addr = a; c.wdata = w; c.wr = wr; c.rd = rd; c.busy = 1'b1; c.done = dn; c.err = er;
    return c;
  endfunction

  // Plan one accepted request; limit>=0 truncates the trace (reset cuts the copy short).
  task automatic plan(input logic [31:0] s, input logic [31:0] d, input int n, input int limit);
    int c;
    logic [31:0] sa, da, v;
    c = 0;
    if (s[1:0] != 2'b00 || d[1:0] != 2'b00) begin
      expQ.push_back(mk(32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1));
      return;
    end
    for (int i = 0; i < n; i++) begin
      sa = s + 32'(4 * i);
      da = d + 32'(4 * i);
      if (limit >= 0 && c >= limit) return;
      expQ.push_back(mk(sa, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0));
      c++;
      if (limit >= 0 && c >= limit) return;
      v = refMem[sa[9:2]];
      refMem[da[9:2]] = v;
      expQ.push_back(mk(da, v, 1'b1, 1'b0, 1'b0, 1'b0));
      c++;
    end
    if (limit >= 0 && c >= limit) return;
    expQ.push_back(mk(32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0));
  endtask

  always @(negedge Clk) begin
    cycT exp, act;
    if (chkEn) begin
      if (expQ.size() > 0) exp = expQ.pop_front();
      else exp = '0;
      act = {Address, WriteData, MemWrite, MemRead, Busy, Done, Err};
      checks++;
      if (act !== exp) begin
        failures++;
        $display("FAIL trace t=%0t got addr=%h wdata=%h wr=%b rd=%b busy=%b done=%b err=%b required addr=%h wdata=%h wr=%b rd=%b busy=%b done=%b err=%b",
                 $time, act.addr, act.wdata, act.wr, act.rd, act.busy, act.done, act.err,
                 exp.addr, exp.wdata, exp.wr, exp.rd, exp.busy, exp.done, exp.err);
      end
    end
  end

  task automatic checkWord(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h required=%h", name, act, exp);
    end
  endtask

  task automatic poke(input int idx, input logic [31:0] val);
    mem[idx] = val;
    refMem[idx] = val;
  endtask

  task automatic startCopy(input logic [31:0] s, input logic [31:0] d, input int n, input int limit);
    @(negedge Clk); #1;
    SrcAddr = s; DstAddr = d; WordCount = CW'(n); Start = 1'b1;
    plan(s, d, n, limit);
    @(posedge Clk); #1;
    Start = 1'b0;
    SrcAddr = $urandom; DstAddr = $urandom; WordCount = CW'($urandom);
  endtask

  task automatic waitIdle();
    int guard;
    guard = 0;
    while (expQ.size() > 0 && guard < 500) begin
      @(negedge Clk);
      guard++;
    end
    if (expQ.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL wait_idle got=%0d pending cycles required=0", expQ.size());
      expQ.delete();
    end
    @(negedge Clk);
  endtask

  initial begin
    logic [31:0] s, d;
    int n, kind;
    Reset = 1'b0; Start = 1'b0; SrcAddr = '0; DstAddr = '0; WordCount = '0;
    for (int i = 0; i < 256; i++) poke(i, $urandom);
    repeat (3) @(posedge Clk);
    #1 chkEn = 1;
    @(negedge Clk); #1 Reset = 1'b1;

    // basic 4-word copy
    poke(0, 32'h11111111); poke(1, 32'h22222222); poke(2, 32'h33333333); poke(3, 32'h44444444);
    startCopy(32'h0, 32'h40, 4, -1);
    waitIdle();
    checkWord("copy_w0", mem[16], 32'h11111111);
    checkWord("copy_w1", mem[17], 32'h22222222);
    checkWord("copy_w2", mem[18], 32'h33333333);
    checkWord("copy_w3", mem[19], 32'h44444444);

    // zero count and misaligned request
    startCopy(32'h10, 32'h20, 0, -1);
    waitIdle();
    startCopy(32'h02, 32'h40, 3, -1);
    waitIdle();

    // reset at the edge ending cycle 5 (READ of word 2)
    poke(34, 32'hDEADBEEF);
    startCopy(32'h0, 32'h80, 8, 5);
    repeat (5) @(negedge Clk);
    #1 Reset = 1'b0;
    @(posedge Clk); #1 Reset = 1'b1;
    waitIdle();
    checkWord("reset_w0", mem[32], 32'h11111111);
    checkWord("reset_w1", mem[33], 32'h22222222);
    checkWord("reset_w2", mem[34], 32'hDEADBEEF);

    // overlapping forward copy propagates the first word
    poke(0, 32'h1); poke(1, 32'h2); poke(2, 32'h3); poke(3, 32'h4);
    startCopy(32'h0, 32'h4, 3, -1);
    waitIdle();
    checkWord("overlap_w1", mem[1], 32'h1);
    checkWord("overlap_w2", mem[2], 32'h1);
    checkWord("overlap_w3", mem[3], 32'h1);

    // Start pulse at the edge ending cycle 3 is ignored
    startCopy(32'h100, 32'h200, 2, -1);
    repeat (3) @(negedge Clk);
    #1 Start = 1'b1; SrcAddr = 32'h300; DstAddr = 32'h340; WordCount = CW'(1);
    @(posedge Clk); #1 Start = 1'b0;
    waitIdle();

    // Start held high through FINISH starts a second copy at that edge
    @(negedge Clk); #1;
    SrcAddr = 32'h140; DstAddr = 32'h180; WordCount = CW'(2); Start = 1'b1;
    plan(32'h140, 32'h180, 2, -1);
    plan(32'h140, 32'h180, 2, -1);
    repeat (6) @(posedge Clk);
    #1 Start = 1'b0;
    waitIdle();

    // randomized requests, including address wrap and misalignment
    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 9);
      n = $urandom_range(0, 5);
      s = 32'($urandom_range(0, 255)) << 2;
      d = 32'($urandom_range(0, 255)) << 2;
      if (kind == 0) s = s | 32'($urandom_range(1, 3));
      else if (kind == 1) d = d | 32'($urandom_range(1, 3));
      else if (kind == 2) s = 32'hFFFFFFF0 + (32'($urandom_range(0, 3)) << 2);
      else if (kind == 3) d = 32'hFFFFFFF4 + (32'($urandom_range(0, 2)) << 2);
      startCopy(s, d, n, -1);
      waitIdle();
      repeat ($urandom_range(0, 2)) @(negedge Clk);
    end

    for (int i = 0; i < 256; i++) begin
      checks++;
      if (mem[i] !== refMem[i]) begin
        failures++;
        $display("FAIL mem_image word=%0d got=%h required=%h", i, mem[i], refMem[i]);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=%0t required=completion", $time);
    $fatal(1, "timeout");
  end
endmodule
